// File: rtl/fetch_pkg.sv
// Shared fetch-side types for the instruction queue.
// Entry layout and queue defaults used by instr_queue and iq_storage.
package fetch_pkg;

  parameter int IQ_DEPTH_DEFAULT = 8;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        addr_err;
    logic        tlb_refill;
    logic        tlb_invalid;
  } fetch_entry_t;

endpackage

// File: rtl/iq_storage.sv
// Instruction queue entry array: two write ports, one async read.
// No reset on contents; validity is tracked by the queue pointers.
module iq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we0,
  input  logic [PTR_W-1:0] i_wa0,
  input  fetch_entry_t     i_wd0,
  input  logic             i_we1,
  input  logic [PTR_W-1:0] i_wa1,
  input  fetch_entry_t     i_wd1,
  input  logic [PTR_W-1:0] i_ra,
  output fetch_entry_t     o_rd
);

  fetch_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_wa0] <= i_wd0;
    if (i_we1) r_mem[i_wa1] <= i_wd1;
  end

  assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode FIFO: up to 2 pushes, 1 pop per cycle, flushable.
// Optional same-cycle empty bypass under INSTR_QUEUE_BYPASS_EN.
module instr_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_num,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr0,
  input  logic [31:0] in_instr1,
  input  logic        in_addr_err,
  input  logic        in_tlb_refill,
  input  logic        in_tlb_invalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_addr_err,
  output logic        out_tlb_refill,
  output logic        out_tlb_invalid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_exc;
  logic             w_two;
  logic             w_push;
  logic             w_byp;
  logic             w_byp_take;
  logic             w_valid;
  logic             w_pop;
  logic             w_we0;
  logic             w_we1;
  logic [PTR_W-1:0] w_nwr;
  logic [CNT_W-1:0] w_cnt_next;
  fetch_entry_t     w_slot0;
  fetch_entry_t     w_slot1;
  fetch_entry_t     w_wd0;
  fetch_entry_t     w_rd;
  fetch_entry_t     w_head_e;

  assign in_ready = (r_count <= CNT_W'(DEPTH - 2));

  // An excepting bundle only ever enqueues slot 0, with a NOP word.
  assign w_exc  = in_addr_err | in_tlb_refill | in_tlb_invalid;
  assign w_two  = !w_exc && (in_num == 2'd2);
  assign w_push = in_valid && in_ready && !flush && resetn;

  assign w_slot0 = '{pc:          in_pc,
                     instr:       w_exc ? NOP_INSTR : in_instr0,
                     addr_err:    in_addr_err,
                     tlb_refill:  in_tlb_refill,
                     tlb_invalid: in_tlb_invalid};
  assign w_slot1 = '{pc:          in_pc + 32'd4,
                     instr:       in_instr1,
                     addr_err:    1'b0,
                     tlb_refill:  1'b0,
                     tlb_invalid: 1'b0};

`ifdef INSTR_QUEUE_BYPASS_EN
  assign w_byp = w_push && (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_valid    = (r_count != '0) || w_byp;
  assign w_pop      = w_valid && out_ready && !flush && resetn;
  assign w_byp_take = w_byp && out_ready;

  // A consumed bypass slot 0 frees port 0 for slot 1 at the tail.
  always_comb begin
    w_we0 = 1'b0;
    w_we1 = 1'b0;
    w_wd0 = w_slot0;
    if (w_push) begin
      if (w_byp_take) begin
        w_we0 = w_two;
        w_wd0 = w_slot1;
      end else begin
        w_we0 = 1'b1;
        w_we1 = w_two;
      end
    end
  end

  assign w_nwr = PTR_W'(w_we0) + PTR_W'(w_we1);

  assign w_cnt_next = r_count
                    + CNT_W'(w_push)
                    + CNT_W'(w_push & w_two)
                    - CNT_W'(w_pop);

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + w_nwr;
      r_count <= w_cnt_next;
      if (w_pop && !w_byp_take) r_head <= r_head + 1'b1;
    end
  end

  iq_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk   (clk),
    .i_we0 (w_we0),
    .i_wa0 (r_tail),
    .i_wd0 (w_wd0),
    .i_we1 (w_we1),
    .i_wa1 (r_tail + 1'b1),
    .i_wd1 (w_slot1),
    .i_ra  (r_head),
    .o_rd  (w_rd)
  );

  assign w_head_e = w_byp ? w_slot0 : w_rd;

  assign out_valid       = w_valid;
  assign out_pc          = w_valid ? w_head_e.pc          : 32'h0;
  assign out_instr       = w_valid ? w_head_e.instr       : 32'h0;
  assign out_addr_err    = w_valid ? w_head_e.addr_err    : 1'b0;
  assign out_tlb_refill  = w_valid ? w_head_e.tlb_refill  : 1'b0;
  assign out_tlb_invalid = w_valid ? w_head_e.tlb_invalid : 1'b0;

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_instr_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_num;
  logic [31:0] in_pc;
  logic [31:0] in_instr0;
  logic [31:0] in_instr1;
  logic        in_addr_err;
  logic        in_tlb_refill;
  logic        in_tlb_invalid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_addr_err;
  logic        out_tlb_refill;
  logic        out_tlb_invalid;

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(8)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_num          (in_num),
    .in_pc           (in_pc),
    .in_instr0       (in_instr0),
    .in_instr1       (in_instr1),
    .in_addr_err     (in_addr_err),
    .in_tlb_refill   (in_tlb_refill),
    .in_tlb_invalid  (in_tlb_invalid),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_addr_err    (out_addr_err),
    .out_tlb_refill  (out_tlb_refill),
    .out_tlb_invalid (out_tlb_invalid)
  );

  fetch_entry_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  pre_size = 0;
  bit  mon_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and enqueue the expected entries.
  task automatic drive(input bit v, input logic [1:0] num,
                       input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input bit ae, input bit tr,
                       input bit ti, input bit ordy, input bit fl,
                       input bit rst);
    fetch_entry_t e;
    bit exc;
    @(posedge clk);
    #1;
    resetn = ~rst;
    flush = fl;
    in_valid = v;
    in_num = num;
    in_pc = pc;
    in_instr0 = i0;
    in_instr1 = i1;
    in_addr_err = ae;
    in_tlb_refill = tr;
    in_tlb_invalid = ti;
    out_ready = ordy;
    pre_size = q.size();
    if (v && (8 - pre_size) >= 2 && !fl && !rst) begin
      exc = ae | tr | ti;
      e.pc = pc;
      e.instr = exc ? 32'h0 : i0;
      e.addr_err = ae;
      e.tlb_refill = tr;
      e.tlb_invalid = ti;
      q.push_back(e);
      if (!exc && num == 2'd2) begin
        e.pc = pc + 32'd4;
        e.instr = i1;
        e.addr_err = 1'b0;
        e.tlb_refill = 1'b0;
        e.tlb_invalid = 1'b0;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 0, 0, 0, ordy, 0, 0);
  endtask

  // Monitor: compares head and handshake against the model mid-cycle.
  initial begin
    bit exp_valid;
    forever begin
      @(negedge clk);
      if (mon_en) begin
`ifdef INSTR_QUEUE_BYPASS_EN
        exp_valid = (q.size() != 0);
`else
        exp_valid = (pre_size != 0);
`endif
        check("in_ready", 32'(in_ready), 32'((8 - pre_size) >= 2));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
          check("out_pc", out_pc, q[0].pc);
          check("out_instr", out_instr, q[0].instr);
          check("out_flags",
                {29'd0, out_addr_err, out_tlb_refill, out_tlb_invalid},
                {29'd0, q[0].addr_err, q[0].tlb_refill, q[0].tlb_invalid});
        end else begin
          check("out_zero",
                out_pc | out_instr |
                {29'd0, out_addr_err, out_tlb_refill, out_tlb_invalid},
                32'h0);
        end
        if (!resetn || flush) q.delete();
        else if (exp_valid && out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    resetn = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_num = 2'd1;
    in_pc = 32'h0;
    in_instr0 = 32'h0;
    in_instr1 = 32'h0;
    in_addr_err = 1'b0;
    in_tlb_refill = 1'b0;
    in_tlb_invalid = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1'b0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1'b0);
    mon_en = 1'b1;
    idle(1'b0);

    // Double push then pop two
    drive(1'b1, 2'd2, 32'hBFC00000, 32'h24020001, 32'h24030002,
          0, 0, 0, 1, 0, 0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill with backpressure, then drain across the wrap
    for (int i = 0; i < 6; i++)
      drive(1'b1, 2'd2, 32'h1000 + 32'(i * 8), 32'hA0 + 32'(i),
            32'hB0 + 32'(i), 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_out_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 4; i++)
      drive(1'b1, 2'd2, 32'h2000 + 32'(i * 8), 32'hC0 + 32'(i),
            32'hD0 + 32'(i), 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) idle(1'b1);

    // Exception bundle enqueues one NOP entry
    drive(1'b1, 2'd2, 32'h00400000, 32'h11111111, 32'h22222222,
          0, 1, 0, 0, 0, 0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Flush race at count 5
    drive(1'b1, 2'd2, 32'h3000, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 2'd2, 32'h3008, 32'h3, 32'h4, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 2'd1, 32'h3010, 32'h5, 32'h6, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 2'd2, 32'h4000, 32'h7, 32'h8, 0, 0, 0, 1, 1, 0);
    idle(1'b1);
    @(negedge clk);
    check("post_flush_valid", 32'(out_valid), 32'h0);

    // Bypass path on an empty queue (only differs in the bypass build)
    drive(1'b1, 2'd2, 32'h5000, 32'h55, 32'h66, 0, 0, 0, 1, 0, 0);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic, including occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      bit v, ae, tr, ti, ordy, fl, rst;
      logic [1:0] num;
      v = ($urandom_range(0, 9) < 7);
      num = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
      ae = ($urandom_range(0, 29) == 0);
      tr = ($urandom_range(0, 29) == 0);
      ti = ($urandom_range(0, 29) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 99) == 0);
      drive(v, num, {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
            $urandom, $urandom, ae, tr, ti, ordy, fl, rst);
    end
    for (int i = 0; i < 10; i++) idle(1'b1);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
